// File: rtl/wptr_ctrl.sv
// Write-side pointer / full-flag controller for an asynchronous FIFO.
// Optional sticky overflow flag is built only when WPTR_CTRL_OVF_EN is defined.
module wptr_ctrl #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - 2
) (
  input  logic                  wclk,
  input  logic                  w_rst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   rptr,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wcount,
  output logic                  overflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] AFULL_LVL = PW'(AFULL_THRESH);

  logic [ADDR_WIDTH:0] wbin_q, wbin_d;
  logic [ADDR_WIDTH:0] wgray_q, wgray_d;
  logic                full_q, full_d;
  logic [ADDR_WIDTH:0] rq1_q, rq2_q;
  logic [ADDR_WIDTH:0] rq2_bin;
  logic [ADDR_WIDTH:0] full_tgt;
  logic                accept;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  for (genvar gi = 0; gi <= ADDR_WIDTH; gi++) begin : g_gray2bin
    assign rq2_bin[gi] = ^(rq2_q >> gi);
  end

  always_comb begin
    accept   = winc & ~full_q;
    wbin_d   = wbin_q + {{ADDR_WIDTH{1'b0}}, accept};
    wgray_d  = wbin_d ^ (wbin_d >> 1);
    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    full_tgt = {~rq2_q[ADDR_WIDTH:ADDR_WIDTH-1], rq2_q[ADDR_WIDTH-2:0]};
    full_d   = (wgray_d == full_tgt);
  end

  always_ff @(posedge wclk) begin
    if (w_rst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      full_q  <= 1'b0;
      rq1_q   <= '0;
      rq2_q   <= '0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      full_q  <= full_d;
      rq1_q   <= rptr;
      rq2_q   <= rq1_q;
    end
  end

`ifdef WPTR_CTRL_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q | (winc & full_q);
  end

  always_ff @(posedge wclk) begin
    if (w_rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign wen         = accept;
  assign waddr       = wbin_q[ADDR_WIDTH-1:0];
  assign wptr        = wgray_q;
  assign full        = full_q;
  assign wcount      = wbin_q - rq2_bin;
  assign almost_full = (wcount >= AFULL_LVL);

endmodule

// File: doc/wptr_ctrl.md
# wptr_ctrl

Write-side pointer and full-flag controller for the JTAG block's asynchronous FIFOs. It is the write-domain counterpart of the read-pointer logic. It owns the binary write address and the Gray-coded write pointer sent to the read domain. It also synchronizes the incoming Gray read pointer and derives full, almost-full, fill count and an optional sticky overflow flag. It sits between the write-domain producer (e.g. TAP shift/capture logic) and the dual-port FIFO memory.

## Interface
Parameters:
- ADDR_WIDTH, 4, memory address bits; FIFO depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- AFULL_THRESH, 2^ADDR_WIDTH-2, fill level at or above which almost_full asserts; legal range 1..2^ADDR_WIDTH.

Ports (one clock; reset is synchronous and active-high):
- wclk  in  1  write-domain clock; all state updates on rising edge.
- w_rst  in  1  synchronous active-high reset.
- winc  in  1  write request from producer.
- rptr  in  ADDR_WIDTH+1  Gray read pointer from read domain; asynchronous to wclk.
- wen  out  1  memory write enable = winc & !full (combinational).
- waddr  out  ADDR_WIDTH  memory write address = low ADDR_WIDTH bits of binary write pointer.
- wptr  out  ADDR_WIDTH+1  registered Gray write pointer to read domain.
- full  out  1  registered full flag.
- almost_full  out  1  wcount >= AFULL_THRESH.
- wcount  out  ADDR_WIDTH+1  fill level as seen from write domain.
- overflow  out  1  sticky write-while-full flag (see Configuration).

## Operation
- State: binary pointer wbin (ADDR_WIDTH+1), Gray pointer wgray, full register, two-flop synchronizer rq1/rq2 for rptr, overflow register.
- Synchronizer: rq1 <= rptr; rq2 <= rq1. Only rq2 is used downstream. No other logic touches rptr.
- Accept: a write is accepted in a cycle where winc=1 and full=0. wbin_next = wbin+1 (mod 2^(ADDR_WIDTH+1)); otherwise wbin holds.
- wgray_next = wbin_next ^ (wbin_next >> 1). wptr is wgray registered; it changes by at most one bit per edge.
- Full: full_next = (wgray_next == {~rq2[ADDR_WIDTH:ADDR_WIDTH-1], rq2[ADDR_WIDTH-2:0]}); registered.
- wcount = wbin − gray2bin(rq2), mod 2^(ADDR_WIDTH+1). Combinational from registered state; always 0..2^ADDR_WIDTH.
- almost_full is combinational from wcount.
- Write while full: wbin, wptr and waddr hold; wen=0; no memory write.
- Wrap-around: wbin rolls from 2^(ADDR_WIDTH+1)−1 to 0; waddr wraps every 2^ADDR_WIDTH writes. The MSB toggle distinguishes full from empty.

## Timing
- Reset values (edge with w_rst=1): wbin=0, wptr=0, waddr=0, rq1=rq2=0, full=0, wcount=0, almost_full=0 (unless AFULL_THRESH=0), overflow=0.
- Reset has priority over winc on the same edge, including mid-operation.
- Write latency: an accepted write at edge N presents the updated waddr/wptr after edge N. Memory writes at the current waddr on edge N.
- Full assertion: full rises on the same edge as the write that fills the FIFO, so no further write is accepted in the next cycle.
- Full deassertion: after rptr changes, rq2 updates 2 edges later and full clears on the 3rd edge. This pessimism is intentional.
- Simultaneous read advance and write: the write is judged against the stale rq2. Full may persist up to 3 cycles extra; overflow is never caused by this staleness.
- wcount and almost_full lag reads by 2 edges and track writes with 0 extra latency.

## Configuration
- WPTR_CTRL_OVF_EN defined: overflow sets on any edge where winc=1 and full=1, stays set until w_rst, and does not block later writes.
- WPTR_CTRL_OVF_EN undefined: overflow register is not built; overflow is tied to 0.

## Test plan
ADDR_WIDTH=3 (depth 8), AFULL_THRESH=6 unless stated.
- Reset, then 8 writes with rptr=0 → full=1 on the 8th write edge; waddr=0; wptr=4'b1100; wcount=8; almost_full=1 from the 6th write.
- With the FIFO full, hold winc=1 for 3 cycles → wptr stays 4'b1100, wen=0; overflow=1 with macro, 0 without.
- From full, set rptr=4'b0001 → full=1 for 2 more edges, clears on the 3rd edge; wcount=7; the next write is accepted and full reasserts.
- 16 writes with rptr following wptr 3 cycles behind → full never asserts; wptr sequence is 0000,0001,0011,0010,…,1000 and back to 0000; waddr wraps twice.
- w_rst pulse after 5 writes, with winc=1 on the reset edge → all outputs 0 on the next cycle; the write is not counted; overflow cleared.
- AFULL_THRESH=8, 7 writes with rptr=0 → almost_full=0 and wcount=7; the 8th write gives almost_full=1 and full=1 on the same edge.
